bp_clint_regs: RTL and testbench
================================

Name: bp_clint_regs

Overview:
- Single-hart core-local interruptor (CLINT) register block. It is the device behind the CLINT window at 0x02xx_xxxx.
- Consumes memory commands routed by the platform address decoder. Holds mipi, mtimecmp and mtime.
- Returns one response per command.
- Drives the software and timer interrupt lines, and exports mtime to the core's time CSR.

Parameters:
- paddr_width_p, 56, physical address width of cmd_addr_i.
- dword_width_p, 64, data width; fixed at 64.
- tick_div_p, 8, clock cycles per mtime increment; legal range ≥1.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o.
- cmd_w_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  paddr_width_p  byte address.
- cmd_size_i  in  2  0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B.
- cmd_data_i  in  dword_width_p  write data; a 4B write uses bits [31:0].
- resp_v_o  out  1  response valid.
- resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i.
- resp_data_o  out  dword_width_p  read data; 0 for writes and errors.
- resp_err_o  out  1  unmapped or illegal access.
- software_irq_o  out  1  mipi[0].
- timer_irq_o  out  1  registered (mtime >= mtimecmp).
- mtime_o  out  dword_width_p  current mtime.

Behaviour:
- Reset (async, reset_n_i=0):
  - State e_idle; mipi=0; mtimecmp=all ones; mtime=0; prescaler=0.
  - resp_v_o=0, resp_data_o=0, resp_err_o=0, software_irq_o=0, timer_irq_o=0.
  - cmd_ready_o=1 after reset release.
  - Reset mid-operation drops any pending response.
- FSM:
  - e_idle: cmd_ready_o=1. An accept moves to e_resp.
  - e_resp: cmd_ready_o=0, resp_v_o=1. Data and err stay stable until resp_ready_i, then return to e_idle.
  - No bypass: at most 1 command per 2 cycles. Latency from accept to resp_v_o is 1 cycle.
- Decode:
  - addr[paddr_width_p-1:16] must equal 0x0200; otherwise err.
  - mipi at 0x0200_0000.
  - mtimecmp at 0x0200_4000/4004.
  - mtime at 0x0200_bff8/bffc.
  - Any other offset is err.
- Size rules:
  - 8B requires addr[2:0]=0.
  - 4B requires addr[1:0]=0; addr[2] selects the upper or lower half.
  - 1B/2B is err.
  - mipi accepts only 4B at offset 0, or 8B.
- Error: no register changes, resp_data_o=0, resp_err_o=1.
- Register effects commit at the accept edge. A read returns the pre-edge value. A 4B read returns the selected half zero-extended.
- mipi: only bit 0 is writable; reads return {63'b0, mipi[0]}.
- Prescaler:
  - Counts 0..tick_div_p-1.
  - On terminal count it wraps to 0 and mtime increments by 1.
  - With tick_div_p=1, mtime increments every cycle.
  - mtime wraps from 2^64-1 to 0.
- Write to mtime:
  - The written value wins over an increment in the same cycle; the increment is lost, and the prescaler keeps running.
  - A 4B write replaces only its half; no carry propagates.
- timer_irq_o is re-evaluated every cycle from registered mtime/mtimecmp, so it lags by 1 cycle. It deasserts 1 cycle after mtimecmp is raised above mtime.
- software_irq_o is driven directly from the mipi flop and updates the cycle after the write.

Decomposition:
- Shared package (bp_common_pkg) holds:
  - CLINT offsets: mipi 0x0000, mtimecmp 0x4000, mtime 0xbff8.
  - The size enum (e_size_1B..e_size_8B).
  - The FSM enum bp_clint_state_e.
- One sub-module, bp_clint_mtime:
  - Contains the prescaler plus the 64b mtime counter.
  - Has a write port with a 2b half-mask.
  - Outputs mtime.

Test Plan:
1. Reset release with tick_div_p=8 → cmd_ready_o=1, timer_irq_o=0, software_irq_o=0; mtime_o=10 after 80 cycles.
2. 8B write 0x20 to 0x0200_4000 → timer_irq_o rises 1 cycle after mtime_o=0x20. Then 8B write all ones → timer_irq_o falls 1 cycle after the accept.
3. 4B write 0x1 to 0x0200_0000 → software_irq_o=1 the next cycle. 4B read there → resp_data_o=0x1, err=0. Write 0x0 → irq clears.
4. Read 0x0200_bff8 with resp_ready_i held 0 for 5 cycles → resp_v_o=1, data and err stable, cmd_ready_o=0 throughout. Second command accepted only after the handshake.
5. 2B read at 0x0200_4000, 8B read at 0x0200_8000, 8B write at 0x0200_4004 → each gives resp_err_o=1, data 0, no register change.
6. 8B write all ones to mtime coinciding with the prescaler terminal count → mtime_o=0xFFFF_FFFF_FFFF_FFFF, then 0 after the next tick. A 4B write 0x5 to 0x0200_bffc leaves the low half unchanged.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared CLINT definitions: window offsets, memory size encoding, FSM states
// and the half-word merge used by the 64b registers that accept 4B writes.
package bp_common_pkg;

    localparam logic [15:0] clint_base_c            = 16'h0200;
    localparam logic [15:0] clint_mipi_offset_c     = 16'h0000;
    localparam logic [15:0] clint_mtimecmp_offset_c = 16'h4000;
    localparam logic [15:0] clint_mtime_offset_c    = 16'hbff8;

    typedef enum logic [1:0] {
        e_size_1B = 2'd0,
        e_size_2B = 2'd1,
        e_size_4B = 2'd2,
        e_size_8B = 2'd3
    } bp_mem_size_e;

    typedef enum logic {
        e_idle = 1'b0,
        e_resp = 1'b1
    } bp_clint_state_e;

    // mask[0] replaces bits [31:0], mask[1] replaces bits [63:32]; no carry between halves
    function automatic logic [63:0] merge_halves(input logic [63:0] old_val,
                                                 input logic [63:0] new_val,
                                                 input logic [1:0]  mask);
        logic [63:0] res;
        res[31:0]  = mask[0] ? new_val[31:0]  : old_val[31:0];
        res[63:32] = mask[1] ? new_val[63:32] : old_val[63:32];
        return res;
    endfunction

endpackage

// File: rtl/bp_clint_mtime.sv
// Prescaled 64b mtime counter. A software write replaces the selected halves and
// wins over a coincident increment; the prescaler is never disturbed by writes.
module bp_clint_mtime
    import bp_common_pkg::*;
#(
    parameter int unsigned tick_div_p = 8
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [1:0]  w_mask_i,
    input  logic [63:0] w_data_i,
    output logic [63:0] mtime_o
);

    localparam int unsigned cnt_w = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
    localparam logic [cnt_w-1:0] term_c = cnt_w'(tick_div_p - 1);

    logic [cnt_w-1:0] presc_q;
    logic [63:0]      mtime_q;
    logic             tick;

    assign tick = (presc_q == term_c);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + cnt_w'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mtime_q <= '0;
        end else if (|w_mask_i) begin
            mtime_q <= merge_halves(mtime_q, w_data_i, w_mask_i);
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/bp_clint_regs.sv
// Single-hart CLINT register block: decodes one command at a time, holds mipi,
// mtimecmp and mtime, and returns a single registered response per command.
module bp_clint_regs
    import bp_common_pkg::*;
#(
    parameter int unsigned paddr_width_p = 56,
    parameter int unsigned dword_width_p = 64,
    parameter int unsigned tick_div_p    = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     cmd_v_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_w_i,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic [1:0]               cmd_size_i,
    input  logic [dword_width_p-1:0] cmd_data_i,
    output logic                     resp_v_o,
    input  logic                     resp_ready_i,
    output logic [dword_width_p-1:0] resp_data_o,
    output logic                     resp_err_o,
    output logic                     software_irq_o,
    output logic                     timer_irq_o,
    output logic [dword_width_p-1:0] mtime_o
);

    localparam int unsigned hi_w = paddr_width_p - 16;

    bp_clint_state_e state_q, state_n;
    bp_mem_size_e    size;

    logic            accept;
    logic [hi_w-1:0] addr_hi;
    logic [15:0]     offset;
    logic [15:0]     dw_offset;
    logic            is_8b, size_ok, base_ok;
    logic            sel_mipi, sel_cmp, sel_mtime, dec_err;
    logic [1:0]      half_mask;
    logic [1:0]      mtime_w_mask;
    logic [63:0]     wdata, rd_raw, rd_val;
    logic [63:0]     mtime, mtimecmp_q;
    logic            mipi_q, timer_irq_q;
    logic [63:0]     resp_data_q;
    logic            resp_err_q;

    assign addr_hi   = cmd_addr_i[paddr_width_p-1:16];
    assign offset    = cmd_addr_i[15:0];
    assign dw_offset = {offset[15:3], 3'b000};
    assign size      = bp_mem_size_e'(cmd_size_i);

    always_comb begin
        is_8b   = (size == e_size_8B);
        size_ok = 1'b0;
        case (size)
            e_size_8B: size_ok = (offset[2:0] == 3'b000);
            e_size_4B: size_ok = (offset[1:0] == 2'b00);
            default:   size_ok = 1'b0;
        endcase
        base_ok   = (addr_hi == hi_w'(clint_base_c));
        // mipi is a single 32b word: a 4B access to its upper half is unmapped
        sel_mipi  = base_ok && size_ok && (dw_offset == clint_mipi_offset_c)
                    && (is_8b || !offset[2]);
        sel_cmp   = base_ok && size_ok && (dw_offset == clint_mtimecmp_offset_c);
        sel_mtime = base_ok && size_ok && (dw_offset == clint_mtime_offset_c);
        dec_err   = !(sel_mipi || sel_cmp || sel_mtime);
        half_mask = is_8b ? 2'b11 : (offset[2] ? 2'b10 : 2'b01);
        wdata     = is_8b ? cmd_data_i : {2{cmd_data_i[31:0]}};
    end

    always_comb begin
        rd_raw = mtime;
        if (sel_mipi) begin
            rd_raw = {63'b0, mipi_q};
        end else if (sel_cmp) begin
            rd_raw = mtimecmp_q;
        end
        if (is_8b) begin
            rd_val = rd_raw;
        end else if (offset[2]) begin
            rd_val = {32'b0, rd_raw[63:32]};
        end else begin
            rd_val = {32'b0, rd_raw[31:0]};
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            e_idle:  if (accept)       state_n = e_resp;
            e_resp:  if (resp_ready_i) state_n = e_idle;
            default: state_n = e_idle;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == e_idle);
        resp_v_o    = (state_q == e_resp);
    end

    assign accept = cmd_v_i && cmd_ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mipi_q      <= 1'b0;
            mtimecmp_q  <= '1;
            timer_irq_q <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            timer_irq_q <= (mtime >= mtimecmp_q);
            if (accept) begin
                resp_err_q  <= dec_err;
                resp_data_q <= (cmd_w_i || dec_err) ? '0 : rd_val;
                if (cmd_w_i && sel_mipi) begin
                    mipi_q <= wdata[0];
                end
                if (cmd_w_i && sel_cmp) begin
                    mtimecmp_q <= merge_halves(mtimecmp_q, wdata, half_mask);
                end
            end
        end
    end

    assign mtime_w_mask = (accept && cmd_w_i && sel_mtime) ? half_mask : 2'b00;

    bp_clint_mtime #(
        .tick_div_p(tick_div_p)
    ) u_mtime (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .w_mask_i (mtime_w_mask),
        .w_data_i (wdata),
        .mtime_o  (mtime)
    );

    assign resp_data_o    = resp_data_q;
    assign resp_err_o     = resp_err_q;
    assign software_irq_o = mipi_q;
    assign timer_irq_o    = timer_irq_q;
    assign mtime_o        = mtime;

endmodule

// File: tb/tb_bp_clint_regs.sv
// Bench for bp_clint_regs: directed scenarios followed by random traffic, all
// compared each cycle against a cycle-level behavioural model of the CLINT.
module tb_bp_clint_regs;

    localparam int unsigned DIV = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_v = 1'b0;
    logic        cmd_ready;
    logic        cmd_w = 1'b0;
    logic [55:0] cmd_addr = '0;
    logic [1:0]  cmd_size = '0;
    logic [63:0] cmd_data = '0;
    logic        resp_v;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        software_irq;
    logic        timer_irq;
    logic [63:0] mtime;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [63:0]     m_mtime, m_cmp, m_rdata;
    logic            m_mipi, m_tirq, m_busy, m_err;
    longint unsigned m_k;

    bp_clint_regs #(
        .paddr_width_p(56),
        .dword_width_p(64),
        .tick_div_p   (DIV)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .cmd_v_i       (cmd_v),
        .cmd_ready_o   (cmd_ready),
        .cmd_w_i       (cmd_w),
        .cmd_addr_i    (cmd_addr),
        .cmd_size_i    (cmd_size),
        .cmd_data_i    (cmd_data),
        .resp_v_o      (resp_v),
        .resp_ready_i  (resp_ready),
        .resp_data_o   (resp_data),
        .resp_err_o    (resp_err),
        .software_irq_o(software_irq),
        .timer_irq_o   (timer_irq),
        .mtime_o       (mtime)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime = '0;
        m_cmp   = '1;
        m_mipi  = 1'b0;
        m_tirq  = 1'b0;
        m_busy  = 1'b0;
        m_rdata = '0;
        m_err   = 1'b0;
        m_k     = 0;
    endtask

    // rid: 0 mipi, 1 mtimecmp, 2 mtime; half: 0 low, 1 high, 2 whole dword
    function automatic bit decode(input logic [55:0] a, input logic [1:0] sz,
                                  output int rid, output int half);
        logic [55:0] dw;
        dw   = {a[55:3], 3'b000};
        rid  = -1;
        half = 2;
        if (sz < 2) return 1'b0;
        if (sz == 3 && a[2:0] != 3'b000) return 1'b0;
        if (sz == 2 && a[1:0] != 2'b00) return 1'b0;
        if (dw == 56'h0200_0000) rid = 0;
        else if (dw == 56'h0200_4000) rid = 1;
        else if (dw == 56'h0200_bff8) rid = 2;
        else return 1'b0;
        if (sz == 2) half = a[2] ? 1 : 0;
        if (rid == 0 && half == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] put(input logic [63:0] old_val, input logic [63:0] d,
                                        input int half);
        if (half == 2) return d;
        if (half == 0) return {old_val[63:32], d[31:0]};
        return {d[31:0], old_val[31:0]};
    endfunction

    task automatic compare_all();
        check("cmd_ready", cmd_ready, !m_busy);
        check("resp_v", resp_v, m_busy);
        if (m_busy) begin
            check("resp_data", resp_data, m_rdata);
            check("resp_err", resp_err, m_err);
        end
        check("software_irq", software_irq, m_mipi);
        check("timer_irq", timer_irq, m_tirq);
        check("mtime", mtime, m_mtime);
    endtask

    // advance one clock: predict the edge from current inputs, then compare
    task automatic step();
        int          rid, half;
        bit          ok, acc, tick;
        logic [63:0] val, nmt, ncmp, rd;
        logic        nmipi, er;
        acc    = !m_busy && cmd_v;
        tick   = (m_k % DIV) == DIV - 1;
        m_tirq = (m_mtime >= m_cmp);
        nmt    = tick ? m_mtime + 64'd1 : m_mtime;
        ncmp   = m_cmp;
        nmipi  = m_mipi;
        rd     = m_rdata;
        er     = m_err;
        if (acc) begin
            ok = decode(cmd_addr, cmd_size, rid, half);
            rd = '0;
            er = !ok;
            if (ok) begin
                val = (rid == 0) ? {63'b0, m_mipi} : (rid == 1) ? m_cmp : m_mtime;
                if (half == 1) val = val >> 32;
                else if (half == 0) val = val & 64'h0000_0000_ffff_ffff;
                if (!cmd_w) rd = val;
                else if (rid == 0) nmipi = cmd_data[0];
                else if (rid == 1) ncmp = put(m_cmp, cmd_data, half);
                else nmt = put(m_mtime, cmd_data, half);
            end
        end
        if (m_busy && resp_ready) m_busy = 1'b0;
        if (acc) begin
            m_busy  = 1'b1;
            m_rdata = rd;
            m_err   = er;
        end
        m_mtime = nmt;
        m_cmp   = ncmp;
        m_mipi  = nmipi;
        @(posedge clk);
        #1;
        m_k++;
        compare_all();
    endtask

    task automatic issue(input logic w, input logic [55:0] a, input logic [1:0] sz,
                         input logic [63:0] d);
        cmd_v    = 1'b1;
        cmd_w    = w;
        cmd_addr = a;
        cmd_size = sz;
        cmd_data = d;
        step();
        cmd_v = 1'b0;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        step();
    endtask

    logic [55:0] addr_pool [10];

    initial begin
        int  n;
        bit  seen;
        addr_pool = '{56'h0200_0000, 56'h0200_0004, 56'h0200_4000, 56'h0200_4004,
                      56'h0200_bff8, 56'h0200_bffc, 56'h0200_8000, 56'h0300_4000,
                      56'h0200_bffa, 56'h0200_4001};
        model_reset();

        // reset state
        #12;
        check("rst_resp_v", resp_v, 1'b0);
        check("rst_timer_irq", timer_irq, 1'b0);
        check("rst_sw_irq", software_irq, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        compare_all();
        check("rel_cmd_ready", cmd_ready, 1'b1);

        // free-running mtime
        repeat (80) step();
        check("mtime_after_80", mtime, 64'd10);

        // timer interrupt rise and fall
        issue(1'b1, 56'h0200_4000, 2'd3, 64'h20);
        finish_resp();
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (mtime == 64'h20) seen = 1'b1;
            else step();
        end
        check("mtime_reach_0x20", {63'b0, seen}, 64'd1);
        check("tirq_lag", timer_irq, 1'b0);
        step();
        check("tirq_rise", timer_irq, 1'b1);
        issue(1'b1, 56'h0200_4000, 2'd3, '1);
        check("tirq_hold_at_accept", timer_irq, 1'b1);
        finish_resp();
        check("tirq_fall", timer_irq, 1'b0);

        // software interrupt
        issue(1'b1, 56'h0200_0000, 2'd2, 64'h1);
        check("swi_set", software_irq, 1'b1);
        finish_resp();
        issue(1'b0, 56'h0200_0000, 2'd2, '0);
        check("mipi_read_data", resp_data, 64'h1);
        check("mipi_read_err", resp_err, 1'b0);
        finish_resp();
        issue(1'b1, 56'h0200_0000, 2'd2, 64'h0);
        finish_resp();
        check("swi_clear", software_irq, 1'b0);

        // response back-pressure with a second command waiting
        resp_ready = 1'b0;
        issue(1'b0, 56'h0200_bff8, 2'd3, '0);
        cmd_v    = 1'b1;
        cmd_w    = 1'b1;
        cmd_addr = 56'h0200_0000;
        cmd_size = 2'd3;
        cmd_data = 64'h1;
        repeat (5) step();
        check("stall_cmd_ready", cmd_ready, 1'b0);
        check("stall_swi_untouched", software_irq, 1'b0);
        resp_ready = 1'b1;
        step();
        check("handshake_idle", cmd_ready, 1'b1);
        step();
        cmd_v = 1'b0;
        check("second_cmd_accepted", resp_v, 1'b1);
        finish_resp();
        check("second_cmd_effect", software_irq, 1'b1);

        // illegal accesses
        issue(1'b0, 56'h0200_4000, 2'd1, '0);
        check("err_2b_err", resp_err, 1'b1);
        check("err_2b_data", resp_data, 64'h0);
        finish_resp();
        issue(1'b0, 56'h0200_8000, 2'd3, '0);
        check("err_unmapped_err", resp_err, 1'b1);
        check("err_unmapped_data", resp_data, 64'h0);
        finish_resp();
        issue(1'b1, 56'h0200_4004, 2'd3, 64'h0);
        check("err_misalign_err", resp_err, 1'b1);
        finish_resp();
        issue(1'b0, 56'h0200_4000, 2'd3, '0);
        check("cmp_unchanged", resp_data, '1);
        finish_resp();

        // mtime write coinciding with a prescaler terminal count, then wrap
        for (int i = 0; i < 2 * DIV && (m_k % DIV) != DIV - 1; i++) step();
        issue(1'b1, 56'h0200_bff8, 2'd3, '1);
        check("mtime_write_wins", mtime, '1);
        finish_resp();
        seen = 1'b0;
        for (int i = 0; i < 2 * DIV && !seen; i++) begin
            if (mtime == 64'h0) seen = 1'b1;
            else step();
        end
        check("mtime_wrap", {63'b0, seen}, 64'd1);
        issue(1'b1, 56'h0200_bffc, 2'd2, 64'h5);
        check("mtime_hi_write", {32'b0, mtime[63:32]}, 64'h5);
        finish_resp();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            n          = $urandom_range(0, 9);
            cmd_v      = ($urandom_range(0, 9) < 6);
            cmd_w      = $urandom_range(0, 1);
            cmd_addr   = addr_pool[n];
            cmd_size   = 2'($urandom_range(0, 3));
            cmd_data   = {$urandom, $urandom};
            if (n == 4 && cmd_w && $urandom_range(0, 1) == 1) cmd_data = {32'hffff_ffff, $urandom};
            resp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        cmd_v      = 1'b0;
        resp_ready = 1'b1;
        step();

        // reset in the middle of a pending response
        resp_ready = 1'b0;
        issue(1'b0, 56'h0200_bff8, 2'd3, '0);
        reset_n = 1'b0;
        #1;
        check("midrst_resp_v", resp_v, 1'b0);
        check("midrst_mtime", mtime, 64'h0);
        check("midrst_sw_irq", software_irq, 1'b0);
        check("midrst_timer_irq", timer_irq, 1'b0);
        model_reset();
        resp_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        compare_all();
        issue(1'b0, 56'h0200_4000, 2'd2, '0);
        check("post_rst_cmp_lo", resp_data, 64'hffff_ffff);
        finish_resp();
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
